// File: rtl/vnu.sv
// Variable node unit for a min-sum LDPC decoder. It adds the channel LLR to all
// incoming check messages and emits saturated extrinsic messages plus a hard decision.
module vnu #(
    parameter int DV    = 3,
    parameter int res_w = 8,
    parameter int ext_w = 3,
    parameter int llr_w = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           in_valid,
    input  logic                           init,
    input  logic [llr_w-1:0]               llr,
    input  logic [res_w*DV-1:0]            r,
    output logic [(res_w+ext_w)*DV-1:0]    q,
    output logic                           hd,
    output logic                           out_valid
);
    localparam int data_w = res_w + ext_w;
    localparam int sum_w  = data_w + $clog2(DV + 1);

    // Symmetric clamp bounds; -2^(data_w-1) is deliberately unreachable.
    localparam logic signed [sum_w-1:0] SAT_MAX = {{(sum_w-data_w+1){1'b0}}, {(data_w-1){1'b1}}};
    localparam logic signed [sum_w-1:0] SAT_MIN = -SAT_MAX;

    if (DV < 2 || DV > 16 || llr_w > data_w) begin : g_param_err
        $error("vnu: DV must be 2..16 and llr_w must not exceed res_w+ext_w");
    end

    function automatic logic signed [data_w-1:0] sat(input logic signed [sum_w-1:0] x);
        logic signed [sum_w-1:0] y;
        if (x > SAT_MAX) begin
            y = SAT_MAX;
        end else if (x < SAT_MIN) begin
            y = SAT_MIN;
        end else begin
            y = x;
        end
        return y[data_w-1:0];
    endfunction

    logic signed [sum_w-1:0]  total_p1_d, total_p1_q;
    logic signed [sum_w-1:0]  reff_p1_d [DV];
    logic signed [sum_w-1:0]  reff_p1_q [DV];
    logic                     vld_p1_q;
    logic signed [data_w-1:0] q_p2_d [DV];
    logic signed [data_w-1:0] q_p2_q [DV];
    logic                     hd_p2_d, hd_p2_q;
    logic                     vld_p2_q;

    // Stage 1: effective messages and exact node total.
    always_comb begin
        total_p1_d = {{(sum_w-llr_w){llr[llr_w-1]}}, llr};
        for (int i = 0; i < DV; i++) begin
            reff_p1_d[i] = init ? '0
                                : {{(sum_w-res_w){r[i*res_w+res_w-1]}}, r[i*res_w +: res_w]};
            total_p1_d   = total_p1_d + reff_p1_d[i];
        end
    end

    // Stage 2: extrinsic subtraction with saturation, sign of total as hard decision.
    always_comb begin
        for (int i = 0; i < DV; i++) begin
            q_p2_d[i] = sat(total_p1_q - reff_p1_q[i]);
        end
        hd_p2_d = total_p1_q[sum_w-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_p1_q <= '0;
            vld_p1_q   <= 1'b0;
            hd_p2_q    <= 1'b0;
            vld_p2_q   <= 1'b0;
            for (int i = 0; i < DV; i++) begin
                reff_p1_q[i] <= '0;
                q_p2_q[i]    <= '0;
            end
        end else if (en) begin
            total_p1_q <= total_p1_d;
            vld_p1_q   <= in_valid;
            hd_p2_q    <= hd_p2_d;
            vld_p2_q   <= vld_p1_q;
            for (int i = 0; i < DV; i++) begin
                reff_p1_q[i] <= reff_p1_d[i];
                q_p2_q[i]    <= q_p2_d[i];
            end
        end
    end

    for (genvar g = 0; g < DV; g++) begin : g_q
        assign q[g*data_w +: data_w] = q_p2_q[g];
    end

    assign hd        = hd_p2_q;
    assign out_valid = vld_p2_q;

endmodule

// File: tb/tb_vnu.sv
// Bench for vnu: default instance (data_w=11) and a no-headroom instance (data_w=8)
// driven in parallel, checked against fixed vectors and an arithmetic model.
module tb_vnu;
    logic        clk = 1'b0;
    logic        rst, en, in_valid, init;
    logic [7:0]  llr;
    logic [23:0] r;
    logic [32:0] q;
    logic [23:0] q_s;
    logic        hd, hd_s, out_valid, out_valid_s;

    always #5 clk = ~clk;

    vnu #(.DV(3), .res_w(8), .ext_w(3), .llr_w(8)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .init(init),
        .llr(llr), .r(r), .q(q), .hd(hd), .out_valid(out_valid));

    vnu #(.DV(3), .res_w(8), .ext_w(0), .llr_w(8)) dut_s (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .init(init),
        .llr(llr), .r(r), .q(q_s), .hd(hd_s), .out_valid(out_valid_s));

    typedef struct {
        bit vld;
        bit chk;
        int q[3];
        int qs[3];
        bit hd;
    } exp_t;

    typedef struct {
        bit init;
        int llr;
        int r[3];
        int q[3];
        int qs[3];
        bit hd;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sbq[$];
    exp_t last;
    exp_t zero_e;

    function automatic int clamp(input int x, input int m);
        return (x > m) ? m : ((x < -m) ? -m : x);
    endfunction

    // Reference: total = llr + sum of effective r; q[i] excludes its own r.
    function automatic exp_t model(input bit v, input bit ini, input int l, input int rr[3]);
        exp_t e;
        int   tot;
        tot = l;
        for (int k = 0; k < 3; k++) tot += ini ? 0 : rr[k];
        for (int i = 0; i < 3; i++) begin
            e.q[i]  = clamp(tot - (ini ? 0 : rr[i]), 1023);
            e.qs[i] = clamp(tot - (ini ? 0 : rr[i]), 127);
        end
        e.hd  = (tot < 0);
        e.vld = v;
        e.chk = v;
        return e;
    endfunction

    function automatic exp_t mk(input int a, input int b, input int c, input bit h);
        exp_t e;
        e.q   = '{a, b, c};
        e.qs  = '{a, b, c};
        e.hd  = h;
        e.vld = 1'b1;
        e.chk = 1'b1;
        return e;
    endfunction

    task automatic check(input string nm, input exp_t e);
        int  aq[3];
        int  as[3];
        bit  bad;
        n_cmp++;
        for (int i = 0; i < 3; i++) begin
            aq[i] = $signed(q[i*11 +: 11]);
            as[i] = $signed(q_s[i*8 +: 8]);
        end
        bad = (out_valid !== e.vld) || (out_valid_s !== e.vld);
        if (e.chk) begin
            for (int i = 0; i < 3; i++)
                if (aq[i] != e.q[i] || as[i] != e.qs[i]) bad = 1'b1;
            if (hd !== e.hd || hd_s !== e.hd) bad = 1'b1;
        end
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got vld=%0b/%0b q=(%0d,%0d,%0d) qs=(%0d,%0d,%0d) hd=%0b/%0b; want vld=%0b q=(%0d,%0d,%0d) qs=(%0d,%0d,%0d) hd=%0b (data checked=%0b)",
                     nm, out_valid, out_valid_s, aq[0], aq[1], aq[2], as[0], as[1], as[2], hd, hd_s,
                     e.vld, e.q[0], e.q[1], e.q[2], e.qs[0], e.qs[1], e.qs[2], e.hd, e.chk);
        end
    endtask

    task automatic cycle(input string nm, input bit e, input bit v, input bit ini,
                         input int l, input int rr[3], input exp_t ex);
        en       = e;
        in_valid = v;
        init     = ini;
        llr      = 8'(l);
        r        = {8'(rr[2]), 8'(rr[1]), 8'(rr[0])};
        ex.vld   = v;
        if (!v) ex.chk = 1'b0;
        @(posedge clk);
        #1;
        if (e) begin
            sbq.push_back(ex);
            last = sbq.pop_front();
        end
        check(nm, last);
    endtask

    task automatic pipe_cleared();
        sbq.delete();
        sbq.push_back(zero_e);
        last = zero_e;
    endtask

    vec_t tbl[8];
    int   z3[3];
    int   rr[3];

    initial begin
        zero_e = mk(0, 0, 0, 1'b0);
        zero_e.vld = 1'b0;
        z3 = '{0, 0, 0};

        tbl[0] = '{1'b0,   10, '{5, -3, 7},         '{14, 22, 12},       '{14, 22, 12},       1'b0};
        tbl[1] = '{1'b0,  -20, '{2, 2, 2},          '{-16, -16, -16},    '{-16, -16, -16},    1'b1};
        tbl[2] = '{1'b0,   -3, '{1, 1, 1},          '{-1, -1, -1},       '{-1, -1, -1},       1'b0};
        tbl[3] = '{1'b1,   -5, '{100, -100, 50},    '{-5, -5, -5},       '{-5, -5, -5},       1'b1};
        tbl[4] = '{1'b0,   -5, '{100, -100, 50},    '{-55, 145, -5},     '{-55, 127, -5},     1'b0};
        tbl[5] = '{1'b0,  127, '{127, 127, 127},    '{381, 381, 381},    '{127, 127, 127},    1'b0};
        tbl[6] = '{1'b0, -128, '{-128, -128, -128}, '{-384, -384, -384}, '{-127, -127, -127}, 1'b1};
        tbl[7] = '{1'b0,    0, '{0, 0, 0},          '{0, 0, 0},          '{0, 0, 0},          1'b0};

        rst = 1'b1; en = 1'b0; in_valid = 1'b0; init = 1'b0; llr = '0; r = '0;
        #2;
        check("reset_state", zero_e);
        @(negedge clk);
        rst = 1'b0;
        pipe_cleared();

        // Back-to-back vectors, then two bubbles to drain.
        for (int k = 0; k < 8; k++) begin
            exp_t e;
            e = mk(tbl[k].q[0], tbl[k].q[1], tbl[k].q[2], tbl[k].hd);
            e.qs = tbl[k].qs;
            cycle($sformatf("vec%0d", k), 1'b1, 1'b1, tbl[k].init, tbl[k].llr, tbl[k].r, e);
        end
        cycle("drain0", 1'b1, 1'b0, 1'b0, 0, z3, zero_e);
        cycle("drain1", 1'b1, 1'b0, 1'b0, 0, z3, zero_e);

        // Stall with a bubble in flight; inputs during en=0 must be ignored.
        rr = '{1, 2, 3};
        cycle("stall_a", 1'b1, 1'b1, 1'b0, 1, rr, mk(6, 5, 4, 1'b0));
        cycle("stall_b", 1'b1, 1'b0, 1'b0, 77, rr, zero_e);
        rr = '{99, 99, 99};
        for (int k = 0; k < 3; k++)
            cycle($sformatf("stall_hold%0d", k), 1'b0, 1'b1, 1'b0, -99, rr, mk(0, 0, 0, 1'b0));
        rr = '{10, 10, 10};
        cycle("stall_c", 1'b1, 1'b1, 1'b0, -50, rr, mk(-30, -30, -30, 1'b1));
        rr = '{-1, 0, 1};
        cycle("stall_d", 1'b1, 1'b1, 1'b0, 40, rr, mk(41, 40, 39, 1'b0));
        cycle("stall_drain0", 1'b1, 1'b0, 1'b0, 0, z3, zero_e);
        cycle("stall_drain1", 1'b1, 1'b0, 1'b0, 0, z3, zero_e);

        // Asynchronous reset between edges with two nodes in flight.
        rr = '{20, 30, 40};
        cycle("rst_n1", 1'b1, 1'b1, 1'b0, 5, rr, model(1'b1, 1'b0, 5, rr));
        cycle("rst_n2", 1'b1, 1'b1, 1'b0, -60, rr, model(1'b1, 1'b0, -60, rr));
        #2 rst = 1'b1;
        #1 check("async_reset", zero_e);
        #1 rst = 1'b0;
        pipe_cleared();
        cycle("post_rst0", 1'b1, 1'b0, 1'b0, 0, z3, zero_e);
        cycle("post_rst1", 1'b1, 1'b0, 1'b0, 0, z3, zero_e);
        rr = '{-7, 8, 9};
        cycle("post_rst_node", 1'b1, 1'b1, 1'b0, 3, rr, model(1'b1, 1'b0, 3, rr));
        cycle("post_rst_out", 1'b1, 1'b0, 1'b0, 0, z3, zero_e);

        // Randomized traffic with stalls, bubbles and first-iteration nodes.
        for (int n = 0; n < 400; n++) begin
            bit e, v, ini;
            int l;
            e   = ($urandom_range(0, 9) < 8);
            v   = ($urandom_range(0, 3) != 0);
            ini = ($urandom_range(0, 9) == 0);
            l   = int'($urandom_range(0, 255)) - 128;
            for (int k = 0; k < 3; k++) rr[k] = int'($urandom_range(0, 255)) - 128;
            cycle("random", e, v, ini, l, rr, model(v, ini, l, rr));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
